// File: rtl/circular_dma_reader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// circular_dma_pkg : shared FSM encoding, AXI constants, burst sizing helper
// Rev 1.0
// ----------------------------------------------------------------------------
package circular_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [31:0] burst_bytes(input int unsigned max_burst,
                                              input int unsigned axis_width);
    return 32'(max_burst * (axis_width / 8));
  endfunction

endpackage
`default_nettype wire

// File: rtl/circular_dma_reader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// circular_dma_reader_if : AXI4 read channels plus AXI4-Stream output bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface circular_dma_reader_if #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_AXIS_WIDTH = 64
);
  logic [C_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [C_AXIS_WIDTH-1:0] m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;
  logic [C_AXIS_WIDTH-1:0] m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready
  );
endinterface
`default_nettype wire

// File: rtl/circular_dma_reader_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// circular_dma_fifo : synchronous first-word-fall-through FIFO, power-of-2 depth
// Rev 1.0
// ----------------------------------------------------------------------------
module circular_dma_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   push,
  input  wire logic [WIDTH-1:0]       din,
  input  wire logic                   pop,
  output logic      [WIDTH-1:0]       dout,
  output logic                        full,
  output logic                        empty,
  output logic      [$clog2(DEPTH):0] free
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [AW-1:0]    rd_idx_q, rd_idx_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_idx_d = wr_idx_q + AW'(do_push);
    rd_idx_d = rd_idx_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign free  = (AW+1)'(DEPTH) - count_q;
  assign dout  = mem_q[rd_idx_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx_q] <= din;
    end
  end
endmodule
`default_nettype wire

// File: rtl/circular_dma_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// circular_dma_reader : drains a memory ring with full AXI4 read bursts to AXIS
// Rev 1.0
// ----------------------------------------------------------------------------
module circular_dma_reader
  import circular_dma_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_MAX_BURST  = 16
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    enable,
  input  wire logic [C_ADDR_WIDTH-1:0] mem_base,
  input  wire logic [31:0]             mem_size,
  input  wire logic [31:0]             write_ptr,
  output logic      [31:0]             read_ptr,
  output logic                         busy,
  output logic                         error,
  circular_dma_reader_if.master        bus
);
  localparam logic [31:0] BURST_BYTES = burst_bytes(C_MAX_BURST, C_AXIS_WIDTH);
  localparam int          FIFO_DEPTH  = 2 * C_MAX_BURST;
  localparam int          FW          = $clog2(FIFO_DEPTH) + 1;

  state_t                  state_q, state_d;
  logic [31:0]             read_ptr_q, read_ptr_d;
  logic [C_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                    error_q, error_d;
  logic [32:0]             avail;
  logic [32:0]             rptr_next;
  logic                    issue;
  logic                    rready;
  logic                    fifo_push, fifo_full, fifo_empty;
  logic [FW-1:0]           fifo_free;

  always_comb begin
    if (write_ptr >= read_ptr_q) begin
      avail = {1'b0, write_ptr} - {1'b0, read_ptr_q};
    end else begin
      avail = {1'b0, write_ptr} + {1'b0, mem_size} - {1'b0, read_ptr_q};
    end
    rptr_next = {1'b0, read_ptr_q} + {1'b0, BURST_BYTES};
    issue = enable & ~error_q & (mem_size != 32'd0) &
            (avail >= {1'b0, BURST_BYTES}) & (fifo_free >= FW'(C_MAX_BURST));
  end

  always_comb begin
    state_d    = state_q;
    read_ptr_d = read_ptr_q;
    araddr_d   = araddr_q;
    error_d    = error_q;
    rready     = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!enable) begin
          error_d = 1'b0;
        end
        if (issue) begin
          state_d  = ADDR;
          araddr_d = mem_base + C_ADDR_WIDTH'(read_ptr_q);
        end
      end
      ADDR: begin
        if (bus.m_axi_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        // FIFO room was reserved at issue time, so this stays high in practice.
        rready = ~fifo_full;
        if (bus.m_axi_rvalid && rready) begin
          fifo_push = 1'b1;
          if (bus.m_axi_rresp != RESP_OKAY) begin
            error_d = 1'b1;
          end
          if (bus.m_axi_rlast) begin
            read_ptr_d = (rptr_next == {1'b0, mem_size}) ? 32'd0 : rptr_next[31:0];
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      read_ptr_q <= '0;
      araddr_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      read_ptr_q <= read_ptr_d;
      araddr_q   <= araddr_d;
      error_q    <= error_d;
    end
  end

  circular_dma_fifo #(
    .WIDTH (C_AXIS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (bus.m_axi_rdata),
    .pop   (bus.m_axis_tready),
    .dout  (bus.m_axis_tdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = 8'(C_MAX_BURST - 1);
  assign bus.m_axi_arsize  = 3'($clog2(C_AXIS_WIDTH / 8));
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_arvalid = (state_q == ADDR);
  assign bus.m_axi_rready  = rready;
  assign bus.m_axis_tvalid = ~fifo_empty;

  assign read_ptr = read_ptr_q;
  assign error    = error_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;
endmodule
`default_nettype wire

// File: tb/tb_circular_dma_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_circular_dma_reader : directed scenarios with an AXI read slave model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_circular_dma_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] mem_base;
  logic [31:0] mem_size;
  logic [31:0] write_ptr;
  logic [31:0] read_ptr;
  logic        busy;
  logic        error;

  circular_dma_reader_if #(.C_ADDR_WIDTH(32), .C_AXIS_WIDTH(64)) bus ();

  circular_dma_reader #(
    .C_ADDR_WIDTH (32),
    .C_AXIS_WIDTH (64),
    .C_MAX_BURST  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mem_base  (mem_base),
    .mem_size  (mem_size),
    .write_ptr (write_ptr),
    .read_ptr  (read_ptr),
    .busy      (busy),
    .error     (error),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] sb[$];
  logic [31:0] pend[$];
  logic [31:0] ar_log[$];
  logic [31:0] rp_log[$];
  int          ar_cnt = 0;
  int          pops = 0;
  int          beat = 0;
  int          bursts_done = 0;
  int          err_target = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int q = 0;
    for (int i = 0; i < budget && q < 5; i++) begin
      tick(1);
      q = busy ? 0 : q + 1;
    end
    check(tag, q >= 5, 1'b1);
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, a};
  endfunction

  // AXI read slave: decides handshakes at negedge, they complete on the next posedge.
  initial begin
    logic        hs_ar = 1'b0;
    logic        hs_r  = 1'b0;
    logic [31:0] ar_l  = '0;
    int          ar_wait = 0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rdata   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hs_ar = 1'b0; hs_r = 1'b0; ar_wait = 0; beat = 0;
        pend.delete();
        bursts_done = ar_cnt;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
      end else begin
        if (hs_ar) begin
          pend.push_back(ar_l);
          ar_log.push_back(ar_l);
          ar_cnt++;
          ar_wait = 0;
        end
        if (hs_r) begin
          sb.push_back(bus.m_axi_rdata);
          if (bus.m_axi_rlast) begin
            void'(pend.pop_front());
            beat = 0;
            bursts_done++;
          end else begin
            beat++;
          end
        end
        if (bus.m_axi_arvalid) begin
          if (ar_wait >= 2) bus.m_axi_arready = 1'b1;
          else begin ar_wait++; bus.m_axi_arready = 1'b0; end
        end else begin
          bus.m_axi_arready = 1'b0;
          ar_wait = 0;
        end
        if (pend.size() > 0) begin
          bus.m_axi_rvalid = 1'b1;
          bus.m_axi_rdata  = beat_data(pend[0] + 32'(beat * 8));
          bus.m_axi_rlast  = (beat == 15);
          bus.m_axi_rresp  = (bursts_done == err_target && beat == 5) ? 2'b10 : 2'b00;
        end else begin
          bus.m_axi_rvalid = 1'b0;
          bus.m_axi_rlast  = 1'b0;
          bus.m_axi_rresp  = 2'b00;
        end
        hs_ar = bus.m_axi_arvalid && bus.m_axi_arready;
        if (hs_ar) ar_l = bus.m_axi_araddr;
        hs_r = bus.m_axi_rvalid && bus.m_axi_rready;
      end
    end
  end

  // Stream sink: every accepted word is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready) begin
        pops++;
        if (sb.size() == 0) check("tdata_unexpected", 64'd1, 64'd0);
        else check("tdata", bus.m_axis_tdata, sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] last_rp = '0;
    forever begin
      @(negedge clk);
      if (read_ptr !== last_rp) begin
        rp_log.push_back(read_ptr);
        last_rp = read_ptr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   a0, p0;
    rst_n = 1'b0; enable = 1'b0; mem_base = '0; mem_size = '0; write_ptr = '0;
    bus.m_axis_tready = 1'b0;
    tick(3);
    check("rst_read_ptr", read_ptr, 0);
    check("rst_arvalid", bus.m_axi_arvalid, 0);
    check("rst_rready", bus.m_axi_rready, 0);
    check("rst_tvalid", bus.m_axis_tvalid, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);

    // single burst
    rst_n = 1'b1; mem_base = 32'h1000_0000; mem_size = 32'h400; write_ptr = 32'h80;
    bus.m_axis_tready = 1'b1; enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin tick(1); found = bus.m_axi_arvalid; end
    check("t1_ar_seen", found, 1);
    check("t1_araddr", bus.m_axi_araddr, 32'h1000_0000);
    check("t1_arlen", bus.m_axi_arlen, 15);
    check("t1_arsize", bus.m_axi_arsize, 3);
    check("t1_arburst", bus.m_axi_arburst, 2'b01);
    wait_quiet("t1_quiet", 300);
    check("t1_read_ptr", read_ptr, 32'h80);
    check("t1_ar_cnt", ar_cnt, 1);
    check("t1_pops", pops, 16);
    check("t1_sb_empty", sb.size(), 0);

    // wrap around the end of the ring
    write_ptr = 32'h380;
    wait_quiet("t2_fill_quiet", 600);
    check("t2_read_ptr_380", read_ptr, 32'h380);
    ar_log.delete(); rp_log.delete(); a0 = ar_cnt;
    write_ptr = 32'h100;
    wait_quiet("t2_quiet", 400);
    check("t2_ar_cnt", ar_cnt - a0, 3);
    check("t2_ar0", ar_log.size() > 0 ? ar_log[0] : 32'hX, 32'h1000_0380);
    check("t2_ar1", ar_log.size() > 1 ? ar_log[1] : 32'hX, 32'h1000_0000);
    check("t2_ar2", ar_log.size() > 2 ? ar_log[2] : 32'hX, 32'h1000_0080);
    check("t2_rp0", rp_log.size() > 0 ? rp_log[0] : 32'hX, 32'h000);
    check("t2_rp1", rp_log.size() > 1 ? rp_log[1] : 32'hX, 32'h080);
    check("t2_rp2", rp_log.size() > 2 ? rp_log[2] : 32'hX, 32'h100);

    // one byte short of a burst, then exactly a burst
    a0 = ar_cnt;
    write_ptr = 32'h17F;
    tick(100);
    check("t3_no_ar", ar_cnt - a0, 0);
    check("t3_no_arvalid", bus.m_axi_arvalid, 0);
    write_ptr = 32'h180;
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin tick(1); found = bus.m_axi_arvalid; end
    check("t3_ar_2cyc", found, 1);
    check("t3_araddr", bus.m_axi_araddr, 32'h1000_0100);
    wait_quiet("t3_quiet", 300);
    check("t3_read_ptr", read_ptr, 32'h180);

    // back-pressure limits fetching to FIFO capacity
    a0 = ar_cnt;
    bus.m_axis_tready = 1'b0;
    write_ptr = 32'h100;
    tick(150);
    check("t4_two_bursts", ar_cnt - a0, 2);
    check("t4_read_ptr", read_ptr, 32'h280);
    check("t4_tvalid", bus.m_axis_tvalid, 1);
    p0 = pops;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 100 && (pops - p0) < 16; i++) tick(1);
    bus.m_axis_tready = 1'b0;
    check("t4_pops16", pops - p0, 16);
    for (int i = 0; i < 20 && (ar_cnt - a0) < 3; i++) tick(1);
    check("t4_third_ar", ar_cnt - a0, 3);
    tick(60);
    check("t4_no_fourth", ar_cnt - a0, 3);
    bus.m_axis_tready = 1'b1;
    wait_quiet("t4_quiet", 800);
    check("t4_read_ptr_end", read_ptr, 32'h100);

    // SLVERR on beat 5
    a0 = ar_cnt; p0 = pops;
    err_target = ar_cnt;
    write_ptr = 32'h200;
    wait_quiet("t5_quiet", 300);
    check("t5_error", error, 1);
    check("t5_one_ar", ar_cnt - a0, 1);
    check("t5_read_ptr", read_ptr, 32'h180);
    check("t5_pops", pops - p0, 16);
    enable = 1'b0;
    tick(2);
    check("t5_error_clear", error, 0);
    enable = 1'b1;
    wait_quiet("t5_resume_quiet", 300);
    check("t5_resume_ptr", read_ptr, 32'h200);
    check("t5_resume_ar", ar_cnt - a0, 2);

    // enable drop mid-burst, then reset mid-burst
    a0 = ar_cnt;
    write_ptr = 32'h300;
    for (int i = 0; i < 40 && beat != 3; i++) tick(1);
    check("t6_beat3", beat, 3);
    enable = 1'b0;
    wait_quiet("t6_quiet", 300);
    check("t6_read_ptr", read_ptr, 32'h280);
    tick(20);
    check("t6_one_ar", ar_cnt - a0, 1);
    enable = 1'b1;
    for (int i = 0; i < 40 && beat != 4; i++) tick(1);
    check("t6_beat4", beat, 4);
    rst_n = 1'b0;
    tick(1);
    check("t6_rst_read_ptr", read_ptr, 0);
    check("t6_rst_tvalid", bus.m_axis_tvalid, 0);
    check("t6_rst_rready", bus.m_axi_rready, 0);
    check("t6_rst_arvalid", bus.m_axi_arvalid, 0);
    sb.delete();
    rst_n = 1'b1; enable = 1'b0;
    tick(3);
    check("t6_post_busy", busy, 0);
    check("t6_post_error", error, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
